// File: rtl/counter_chk_pkg.sv
// counter_chk_pkg
// Shared types and the counter next-value rule used by counter_checker.
//   chk_state_t : checker FSM encoding (SYNC, CHECK, HALT)
//   cnt_next()  : next value of the observed counter, given its control inputs
package counter_chk_pkg;

    // Widest counter that cnt_next handles. Callers zero-extend into this width
    // and truncate the result back to their own width. Because only +1/-1 and
    // plain loads are involved, the low bits of the result are already the
    // correct modulo-2^WIDTH value for any WIDTH up to CNT_MAX_W.
    localparam int CNT_MAX_W = 32;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        CHECK = 2'd1,
        HALT  = 2'd2
    } chk_state_t;

    // Counter rule: load has priority over count-enable, otherwise hold.
    function automatic logic [CNT_MAX_W-1:0] cnt_next(
        input logic [CNT_MAX_W-1:0] cur,
        input logic                 load,
        input logic                 en,
        input logic                 up,
        input logic [CNT_MAX_W-1:0] din
    );
        logic [CNT_MAX_W-1:0] nxt;
        if (load) begin
            nxt = din;
        end else if (en) begin
            nxt = up ? (cur + CNT_MAX_W'(1)) : (cur - CNT_MAX_W'(1));
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous clear, used as the checker error count.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : add one this cycle unless already at all-ones
//   clr   : synchronous clear, wins over inc
//   q     : current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear first, then increment only while below all-ones so the
    // count sticks at its maximum instead of wrapping back to zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q = count_q;

endmodule

// File: rtl/counter_checker.sv
// counter_checker
// Observer that sits beside an up/down counter, runs its own model of that
// counter and flags every cycle where the counter output disagrees with it.
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   obs_load     : observed counter load strobe
//   obs_en       : observed counter count-enable
//   obs_up       : observed counter direction (1 = up, 0 = down)
//   obs_din      : observed counter load value
//   obs_count    : observed counter output
//   resync       : pulse, re-seed the model from obs_count and leave HALT
//   chk_clr      : pulse, clear err_sticky, err_count and the first-error capture
//   mismatch     : registered one-cycle pulse per detected mismatch
//   err_sticky   : set on a mismatch, held until chk_clr or reset
//   err_count    : saturating number of mismatches
//   first_exp    : model value at the first mismatch since the last clear
//   first_got    : observed value at the first mismatch since the last clear
//   halted       : 1 while the checker is frozen after an error (STOP_ON_ERR)
// WIDTH must not exceed counter_chk_pkg::CNT_MAX_W.
module counter_checker #(
    parameter int WIDTH       = 8,
    parameter int ERR_CNT_W   = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 obs_load,
    input  logic                 obs_en,
    input  logic                 obs_up,
    input  logic [WIDTH-1:0]     obs_din,
    input  logic [WIDTH-1:0]     obs_count,
    input  logic                 resync,
    input  logic                 chk_clr,
    output logic                 mismatch,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     first_exp,
    output logic [WIDTH-1:0]     first_got,
    output logic                 halted
);

    import counter_chk_pkg::*;

    chk_state_t       state_q;
    chk_state_t       state_d;
    logic [WIDTH-1:0] expVal_q;
    logic [WIDTH-1:0] expVal_d;
    logic [WIDTH-1:0] modelSrc;
    logic [WIDTH-1:0] modelNext;
    logic             mismatch_q;
    logic             errSticky_q;
    logic             errSticky_d;
    logic [WIDTH-1:0] firstExp_q;
    logic [WIDTH-1:0] firstExp_d;
    logic [WIDTH-1:0] firstGot_q;
    logic [WIDTH-1:0] firstGot_d;
    logic             compareEn;
    logic             haltedNow;
    logic             errDetect;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. A resync request overrides everything and always lands
    // in SYNC, which spends exactly one cycle re-seeding the model.
    always_comb begin
        state_d = state_q;
        if (resync) begin
            state_d = SYNC;
        end else begin
            case (state_q)
                SYNC:    state_d = CHECK;
                CHECK:   if (errDetect && STOP_ON_ERR) state_d = HALT;
                HALT:    state_d = HALT;
                default: state_d = SYNC;
            endcase
        end
    end

    // FSM outputs. Comparison is suppressed in the resync cycle because the
    // model is about to be replaced anyway.
    always_comb begin
        compareEn = (state_q == CHECK) && !resync;
        haltedNow = (state_q == HALT);
    end

    assign errDetect = compareEn && (obs_count != expVal_q);

    // Model next value. While syncing, the counter's own output seeds the model;
    // in CHECK the model advances from its own value, so a single bad sample
    // does not corrupt it. HALT (and any illegal state) holds the model.
    always_comb begin
        modelSrc = expVal_q;
        if (resync || (state_q == SYNC)) begin
            modelSrc = obs_count;
        end
        modelNext = WIDTH'(cnt_next(CNT_MAX_W'(modelSrc), obs_load, obs_en, obs_up,
                                    CNT_MAX_W'(obs_din)));
        expVal_d = expVal_q;
        if (resync || (state_q == SYNC) || (state_q == CHECK)) begin
            expVal_d = modelNext;
        end
    end

    // Error bookkeeping. A clear beats a simultaneous mismatch; the first-error
    // capture only loads while nothing has been recorded since the last clear.
    always_comb begin
        errSticky_d = errSticky_q;
        firstExp_d  = firstExp_q;
        firstGot_d  = firstGot_q;
        if (chk_clr) begin
            errSticky_d = 1'b0;
            firstExp_d  = '0;
            firstGot_d  = '0;
        end else if (errDetect) begin
            errSticky_d = 1'b1;
            if (!errSticky_q) begin
                firstExp_d = expVal_q;
                firstGot_d = obs_count;
            end
        end
    end

    // Datapath registers: model value, mismatch pulse and debug capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expVal_q    <= '0;
            mismatch_q  <= 1'b0;
            errSticky_q <= 1'b0;
            firstExp_q  <= '0;
            firstGot_q  <= '0;
        end else begin
            expVal_q    <= expVal_d;
            mismatch_q  <= errDetect;
            errSticky_q <= errSticky_d;
            firstExp_q  <= firstExp_d;
            firstGot_q  <= firstGot_d;
        end
    end

    sat_counter #(
        .W (ERR_CNT_W)
    ) u_errCount (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (errDetect),
        .clr   (chk_clr),
        .q     (err_count)
    );

    assign mismatch   = mismatch_q;
    assign err_sticky = errSticky_q;
    assign first_exp  = firstExp_q;
    assign first_got  = firstGot_q;
    assign halted     = haltedNow;

endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker
// Drives three checkers from one stimulus stream: default settings, stop on
// error, and a 2-bit error counter. An emulated counter provides obs_count,
// with occasional forced wrong values, and a behavioural model of the checker
// predicts every output.
module tb_counter_checker;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic       en;
    logic       up;
    logic [7:0] din;
    logic [7:0] obs;
    logic       resync;
    logic       clr;

    logic        mis0, sticky0, halt0, mis1, sticky1, halt1, mis2, sticky2, halt2;
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;
    logic [7:0]  fexp0, fgot0, fexp1, fgot1, fexp2, fgot2;
    logic [34:0] dAll [3];

    int checks;
    int failures;
    int cycle;
    int ctr;

    // Behavioural model, one slot per checker instance.
    bit mSync [3];
    bit mHalt [3];
    bit mMis [3];
    bit mSticky [3];
    int mExp [3];
    int mCnt [3];
    int mFExp [3];
    int mFGot [3];
    int cntMax [3] = '{65535, 65535, 3};
    bit stopCfg [3] = '{1'b0, 1'b1, 1'b0};

    counter_checker #(.WIDTH(8), .ERR_CNT_W(16), .STOP_ON_ERR(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .obs_load(load), .obs_en(en), .obs_up(up),
        .obs_din(din), .obs_count(obs), .resync(resync), .chk_clr(clr),
        .mismatch(mis0), .err_sticky(sticky0), .err_count(cnt0),
        .first_exp(fexp0), .first_got(fgot0), .halted(halt0));

    counter_checker #(.WIDTH(8), .ERR_CNT_W(16), .STOP_ON_ERR(1'b1)) dutStop (
        .clk(clk), .rst_n(rst_n), .obs_load(load), .obs_en(en), .obs_up(up),
        .obs_din(din), .obs_count(obs), .resync(resync), .chk_clr(clr),
        .mismatch(mis1), .err_sticky(sticky1), .err_count(cnt1),
        .first_exp(fexp1), .first_got(fgot1), .halted(halt1));

    counter_checker #(.WIDTH(8), .ERR_CNT_W(2), .STOP_ON_ERR(1'b0)) dutSmall (
        .clk(clk), .rst_n(rst_n), .obs_load(load), .obs_en(en), .obs_up(up),
        .obs_din(din), .obs_count(obs), .resync(resync), .chk_clr(clr),
        .mismatch(mis2), .err_sticky(sticky2), .err_count(cnt2),
        .first_exp(fexp2), .first_got(fgot2), .halted(halt2));

    assign dAll[0] = {mis0, sticky0, cnt0, fexp0, fgot0, halt0};
    assign dAll[1] = {mis1, sticky1, cnt1, fexp1, fgot1, halt1};
    assign dAll[2] = {mis2, sticky2, 14'd0, cnt2, fexp2, fgot2, halt2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter contract in plain modulo-256 arithmetic on the current inputs.
    function automatic int nxt(int v);
        if (load) return int'(din);
        if (!en) return v;
        return up ? (v + 1) % 256 : (v + 255) % 256;
    endfunction

    function automatic logic [34:0] expAll(int i);
        return {mMis[i], mSticky[i], 16'(mCnt[i]), 8'(mFExp[i]), 8'(mFGot[i]), mHalt[i]};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            mSync[i] = 1'b1;  mHalt[i] = 1'b0;  mMis[i] = 1'b0;  mSticky[i] = 1'b0;
            mExp[i] = 0;  mCnt[i] = 0;  mFExp[i] = 0;  mFGot[i] = 0;
        end
        ctr = 0;
    endtask

    // Predict the effect of the coming rising edge from the current inputs.
    task automatic modelEdge();
        for (int i = 0; i < 3; i++) begin
            bit doCmp;
            bit bad;
            int newExp;
            doCmp = !mSync[i] && !mHalt[i] && !resync;
            bad   = doCmp && (int'(obs) != mExp[i]);
            if (resync || mSync[i]) newExp = nxt(int'(obs));
            else if (mHalt[i])      newExp = mExp[i];
            else                    newExp = nxt(mExp[i]);
            mMis[i] = bad;
            if (clr) begin
                mSticky[i] = 1'b0;  mCnt[i] = 0;  mFExp[i] = 0;  mFGot[i] = 0;
            end else if (bad) begin
                if (!mSticky[i]) begin
                    mFExp[i] = mExp[i];
                    mFGot[i] = int'(obs);
                end
                mSticky[i] = 1'b1;
                if (mCnt[i] < cntMax[i]) mCnt[i]++;
            end
            if (resync) begin
                mSync[i] = 1'b1;  mHalt[i] = 1'b0;
            end else if (mSync[i]) begin
                mSync[i] = 1'b0;
            end else if (bad && stopCfg[i]) begin
                mHalt[i] = 1'b1;
            end
            mExp[i] = newExp;
        end
        ctr = nxt(ctr);
    endtask

    // One clock: model, edge, then restore default (correct) obs and clear pulses.
    task automatic step();
        modelEdge();
        @(posedge clk);
        #1;
        cycle++;
        obs    = 8'(ctr);
        resync = 1'b0;
        clr    = 1'b0;
    endtask

    task automatic applyStimulus(input bit l, input bit e, input bit u, input logic [7:0] d);
        load = l;  en = e;  up = u;  din = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;  resync = 1'b0;  clr = 1'b0;  obs = 8'h00;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dAll[i] !== 35'd0) begin
                failures++;
                $display("[TB] FAIL reset dut%0d: got %h want 0", i, dAll[i]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_count_up();
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
        repeat (20) begin
            step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dAll[i] !== expAll(i)) begin
                    failures++;
                    $display("[TB] FAIL count_up dut%0d cyc %0d: got %h want %h", i, cycle, dAll[i], expAll(i));
                end
            end
        end
        checks++;
        if (cnt0 !== 16'd0) begin
            failures++;
            $display("[TB] FAIL count_up err_count: got %0d want 0", cnt0);
        end
    endtask

    task automatic test_wrap();
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hFE);
        step();
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
        repeat (4) begin
            step();
            checks++;
            if (mis0 !== 1'b0 || dAll[0] !== expAll(0)) begin
                failures++;
                $display("[TB] FAIL wrap_up cyc %0d: got %h want %h", cycle, dAll[0], expAll(0));
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h01);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        repeat (4) begin
            step();
            checks++;
            if (mis0 !== 1'b0 || dAll[0] !== expAll(0)) begin
                failures++;
                $display("[TB] FAIL wrap_down cyc %0d: got %h want %h", cycle, dAll[0], expAll(0));
            end
        end
    endtask

    task automatic test_error_capture();
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h04);
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        step();
        obs = 8'h05;
        step();
        checks++;
        if ({mis0, sticky0, cnt0, fexp0, fgot0} !== {1'b1, 1'b1, 16'd1, 8'h04, 8'h05}) begin
            failures++;
            $display("[TB] FAIL capture mis/sticky/cnt/fexp/fgot: got %b %b %0d %h %h want 1 1 1 04 05",
                     mis0, sticky0, cnt0, fexp0, fgot0);
        end
        checks++;
        if (halt1 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL capture halted_stop: got %b want 1", halt1);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dAll[i] !== expAll(i)) begin
                failures++;
                $display("[TB] FAIL capture_after dut%0d: got %h want %h", i, dAll[i], expAll(i));
            end
        end
    endtask

    task automatic test_halt_resync();
        obs = 8'(ctr) ^ 8'h10;
        step();
        checks++;
        if ({cnt1, halt1, mis1, cnt0} !== {16'd1, 1'b1, 1'b0, 16'd2}) begin
            failures++;
            $display("[TB] FAIL halt cnt_stop/halted/mis_stop/cnt: got %0d %b %b %0d want 1 1 0 2",
                     cnt1, halt1, mis1, cnt0);
        end
        resync = 1'b1;
        obs    = 8'(ctr) ^ 8'h20;
        step();
        checks++;
        if ({mis0, mis1, halt1} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL resync_cycle mis/mis_stop/halted: got %b%b%b want 000", mis0, mis1, halt1);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
        repeat (6) begin
            step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dAll[i] !== expAll(i)) begin
                    failures++;
                    $display("[TB] FAIL after_resync dut%0d cyc %0d: got %h want %h", i, cycle, dAll[i], expAll(i));
                end
            end
        end
    endtask

    task automatic test_clr_collision();
        obs = 8'(ctr + 3);
        clr = 1'b1;
        step();
        checks++;
        if ({mis0, sticky0, cnt0, fexp0, fgot0} !== {1'b1, 1'b0, 16'd0, 8'h00, 8'h00}) begin
            failures++;
            $display("[TB] FAIL clr_collision mis/sticky/cnt/fexp/fgot: got %b %b %0d %h %h want 1 0 0 00 00",
                     mis0, sticky0, cnt0, fexp0, fgot0);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dAll[i] !== expAll(i)) begin
                failures++;
                $display("[TB] FAIL clr_after dut%0d: got %h want %h", i, dAll[i], expAll(i));
            end
        end
    endtask

    task automatic test_saturate_and_async_reset();
        repeat (5) begin
            obs = 8'(ctr) ^ 8'h01;
            step();
            step();
        end
        checks++;
        if ({cnt2, sticky2} !== {2'd3, 1'b1} || dAll[2] !== expAll(2)) begin
            failures++;
            $display("[TB] FAIL saturate err_count_w2: got %0d sticky %b want 3 sticky 1", cnt2, sticky2);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        obs   = 8'h00;
        modelReset();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dAll[i] !== 35'd0) begin
                failures++;
                $display("[TB] FAIL async_reset dut%0d: got %h want 0", i, dAll[i]);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) begin
            step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dAll[i] !== expAll(i)) begin
                    failures++;
                    $display("[TB] FAIL post_reset dut%0d cyc %0d: got %h want %h", i, cycle, dAll[i], expAll(i));
                end
            end
        end
    endtask

    task automatic test_random();
        repeat (400) begin
            applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 1) == 1, 8'($urandom));
            if ($urandom_range(0, 14) == 0) obs = 8'(ctr) ^ 8'(1 << $urandom_range(0, 7));
            resync = ($urandom_range(0, 39) == 0);
            clr    = ($urandom_range(0, 29) == 0);
            step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dAll[i] !== expAll(i)) begin
                    failures++;
                    $display("[TB] FAIL random dut%0d cyc %0d: got %h want %h", i, cycle, dAll[i], expAll(i));
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cycle    = 0;
        test_reset();
        test_count_up();
        test_wrap();
        test_error_capture();
        test_halt_resync();
        test_clr_collision();
        test_saturate_and_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
